// File: rtl/rr_arb4_16.sv
// rr_arb4_16: round-robin arbiter and sequencer for a shared 4-way, 16-bit data path.
//
// Four requesters (A, B, C, D) compete for one registered 16-bit output. The current owner
// streams one word per cycle onto DO (with DV) for as long as it holds its request. When
// the owner drops its request, it is released and the block re-arbitrates in that same
// cycle, so the next owner is granted with no idle gap. The released owner gets the lowest
// priority for that arbitration.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   REQ   - request per source (bit0=A .. bit3=D)
//   A..D  - source words, WIDTH bits each, zero-extended onto DO
//   GNT   - registered one-hot grant (0000 when idle)
//   S     - registered select code of the current or last owner
//   DO    - registered output word, held when DV=0
//   DV    - DO was loaded on the previous edge
//   BUSY  - high while a grant is held
//
// Optional feature: define ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST beats. The
// cap forces a release on the last beat. A sole requester is re-granted at once.

module rr_arb4_16 #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       REQ,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   output logic [3:0]       GNT,
   output logic [1:0]       S,
   output logic [15:0]      DO,
   output logic             DV,
   output logic             BUSY
);

   if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("rr_arb4_16: WIDTH must be in 1..16");
   end
   if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
      $error("rr_arb4_16: MAX_BURST must be in 1..255");
   end

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e      state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;   // last owner; the scan starts just above it
   logic [3:0]  gnt_q, gnt_d;
   logic [1:0]  s_q, s_d;       // doubles as the owner index while in StGrant
   logic [15:0] do_q, do_d;
   logic        dv_q, dv_d;

`ifdef ARB_BURST_LIMIT_EN
   localparam logic [7:0] LastBeat = 8'(MAX_BURST - 1);
   logic [7:0] cnt_q, cnt_d;
`endif

   // First requester scanning upward from last+1, wrapping. Returns last when req is empty.
   function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
      logic [1:0] idx;
      rr_pick = last;
      // Walk from the farthest candidate to the nearest so the nearest hit wins.
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (req[idx]) begin
            rr_pick = idx;
         end
      end
   endfunction

   logic [WIDTH-1:0] sel_word;
   logic [1:0]       win_idle;
   logic [1:0]       win_rel;
   logic             release_now;

   always_comb begin
      sel_word = A;
      unique case (s_q)
         2'd0: sel_word = A;
         2'd1: sel_word = B;
         2'd2: sel_word = C;
         2'd3: sel_word = D;
      endcase
   end

   assign win_idle = rr_pick(ptr_q, REQ);
   // On release the old owner becomes the pointer, giving it lowest priority.
   assign win_rel  = rr_pick(s_q, REQ);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      s_d         = s_q;
      do_d        = do_q;
      dv_d        = 1'b0;
      release_now = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
      cnt_d       = cnt_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (|REQ) begin
               state_d = StGrant;
               gnt_d   = 4'b0001 << win_idle;
               s_d     = win_idle;
`ifdef ARB_BURST_LIMIT_EN
               cnt_d   = 8'd0;
`endif
            end
         end

         StGrant: begin
            if (REQ[s_q]) begin
               do_d = 16'(sel_word);
               dv_d = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
               cnt_d = cnt_q + 8'd1;
               // The final beat still transfers; the release rides on the same edge.
               if (cnt_q == LastBeat) begin
                  release_now = 1'b1;
               end
`endif
            end else begin
               release_now = 1'b1;
            end

            if (release_now) begin
               ptr_d = s_q;
               if (|REQ) begin
                  gnt_d = 4'b0001 << win_rel;
                  s_d   = win_rel;
`ifdef ARB_BURST_LIMIT_EN
                  cnt_d = 8'd0;
`endif
               end else begin
                  gnt_d   = 4'b0000;
                  state_d = StIdle;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ptr_q   <= 2'd3;
         gnt_q   <= 4'b0000;
         s_q     <= 2'd0;
         do_q    <= 16'h0000;
         dv_q    <= 1'b0;
`ifdef ARB_BURST_LIMIT_EN
         cnt_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         s_q     <= s_d;
         do_q    <= do_d;
         dv_q    <= dv_d;
`ifdef ARB_BURST_LIMIT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign GNT  = gnt_q;
   assign S    = s_q;
   assign DO   = do_q;
   assign DV   = dv_q;
   assign BUSY = (state_q == StGrant);

endmodule

// File: tb/tb_rr_arb4_16.sv
// Bench for rr_arb4_16: a 16-bit and an 8-bit instance share all stimulus.
module tb_rr_arb4_16;

   localparam int MaxBurst = 4;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] a, b, c, d;

   logic [3:0]  gnt, gnt8;
   logic [1:0]  s, s8;
   logic [15:0] dout, dout8;
   logic        dv, dv8, busy, busy8;

   int n_vec;
   int n_fail;

   rr_arb4_16 #(.WIDTH(16), .MAX_BURST(MaxBurst)) dut (
      .clk(clk), .rst_n(rst_n), .REQ(req),
      .A(a), .B(b), .C(c), .D(d),
      .GNT(gnt), .S(s), .DO(dout), .DV(dv), .BUSY(busy)
   );

   rr_arb4_16 #(.WIDTH(8), .MAX_BURST(MaxBurst)) dut8 (
      .clk(clk), .rst_n(rst_n), .REQ(req),
      .A(a[7:0]), .B(b[7:0]), .C(c[7:0]), .D(d[7:0]),
      .GNT(gnt8), .S(s8), .DO(dout8), .DV(dv8), .BUSY(busy8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: abstract owner/pointer/beat bookkeeping.
   bit          m_idle;
   int          m_owner, m_ptr, m_beats;
   logic [3:0]  m_gnt;
   logic [1:0]  m_s;
   logic [15:0] m_do, m_do8;
   logic        m_dv;

   function automatic int pick(input int last, input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_give(input int w);
      m_idle  = 0;
      m_owner = w;
      m_s     = 2'(w);
      m_beats = 0;
   endtask

   task automatic model_edge(input logic rst, input logic [3:0] r,
                             input logic [15:0] wa, wb, wc, wd);
      logic [15:0] words [4];
      bit rel;
      words[0] = wa; words[1] = wb; words[2] = wc; words[3] = wd;
      if (!rst) begin
         m_idle = 1; m_owner = 0; m_ptr = 3; m_beats = 0;
         m_s = 2'd0; m_do = 16'h0; m_do8 = 16'h0; m_dv = 1'b0;
      end else if (m_idle) begin
         m_dv = 1'b0;
         if (r != 4'b0) model_give(pick(m_ptr, r));
      end else begin
         rel = 0;
         if (r[m_owner]) begin
            m_do  = words[m_owner];
            m_do8 = {8'h00, words[m_owner][7:0]};
            m_dv  = 1'b1;
            m_beats++;
`ifdef ARB_BURST_LIMIT_EN
            if (m_beats == MaxBurst) rel = 1;
`endif
         end else begin
            m_dv = 1'b0;
            rel  = 1;
         end
         if (rel) begin
            m_ptr = m_owner;
            if (r != 4'b0) model_give(pick(m_ptr, r));
            else m_idle = 1;
         end
      end
      m_gnt = m_idle ? 4'b0000 : (4'b0001 << m_owner);
   endtask

   // Drive one cycle of inputs, advance the model, sample #1 after the edge.
   task automatic apply(input logic rst, input logic [3:0] r);
      rst_n = rst;
      req   = r;
      model_edge(rst, r, a, b, c, d);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                        input logic [15:0] edo, input logic [15:0] edo8,
                        input logic edv, input logic ebusy);
      n_vec++;
      if (gnt !== eg || s !== es || dout !== edo || dv !== edv || busy !== ebusy ||
          gnt8 !== eg || s8 !== es || dout8 !== edo8 || dv8 !== edv || busy8 !== ebusy) begin
         n_fail++;
         $display("FAIL %s: got gnt=%b s=%0d do=%h do8=%h dv=%b busy=%b (w8 gnt=%b s=%0d dv=%b busy=%b) want gnt=%b s=%0d do=%h do8=%h dv=%b busy=%b",
                  name, gnt, s, dout, dout8, dv, busy, gnt8, s8, dv8, busy8,
                  eg, es, edo, edo8, edv, ebusy);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [3:0]  gnt;
      logic [1:0]  s;
      logic [15:0] do16;
      logic [15:0] do8;
      logic        dv;
      logic        busy;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic [3:0] r, input logic [3:0] g,
                               input logic [1:0] sv, input logic [15:0] d16,
                               input logic [15:0] d8, input logic v, input logic bz);
      vec_t t;
      t.rst = rst; t.req = r; t.gnt = g; t.s = sv;
      t.do16 = d16; t.do8 = d8; t.dv = v; t.busy = bz;
      return t;
   endfunction

   vec_t tbl[$];

   initial begin
      n_vec  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      req    = 4'b0;
      a = 16'h11AB; b = 16'h2222; c = 16'h1234; d = 16'h4444;

      // Reset, single source C, 8-bit zero extension, fairness A->B->C->D->A.
      tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(1, 4'hF, 4'h1, 0, 16'h0000, 16'h0000, 0, 1));
      tbl.push_back(mk(1, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(1, 4'h4, 4'h4, 2, 16'h0000, 16'h0000, 0, 1));
      tbl.push_back(mk(1, 4'h4, 4'h4, 2, 16'h1234, 16'h0034, 1, 1));
      tbl.push_back(mk(1, 4'h4, 4'h4, 2, 16'h1234, 16'h0034, 1, 1));
      tbl.push_back(mk(1, 4'h4, 4'h4, 2, 16'h1234, 16'h0034, 1, 1));
      tbl.push_back(mk(1, 4'h0, 4'h0, 2, 16'h1234, 16'h0034, 0, 0));
      tbl.push_back(mk(1, 4'h0, 4'h0, 2, 16'h1234, 16'h0034, 0, 0));
      tbl.push_back(mk(1, 4'h1, 4'h1, 0, 16'h1234, 16'h0034, 0, 1));
      tbl.push_back(mk(1, 4'h1, 4'h1, 0, 16'h11AB, 16'h00AB, 1, 1));
      tbl.push_back(mk(1, 4'h0, 4'h0, 0, 16'h11AB, 16'h00AB, 0, 0));
      tbl.push_back(mk(0, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(1, 4'hF, 4'h1, 0, 16'h0000, 16'h0000, 0, 1));
      tbl.push_back(mk(1, 4'hF, 4'h1, 0, 16'h11AB, 16'h00AB, 1, 1));
      tbl.push_back(mk(1, 4'hF, 4'h1, 0, 16'h11AB, 16'h00AB, 1, 1));
      tbl.push_back(mk(1, 4'hE, 4'h2, 1, 16'h11AB, 16'h00AB, 0, 1));
      tbl.push_back(mk(1, 4'hF, 4'h2, 1, 16'h2222, 16'h0022, 1, 1));
      tbl.push_back(mk(1, 4'hF, 4'h2, 1, 16'h2222, 16'h0022, 1, 1));
      tbl.push_back(mk(1, 4'hD, 4'h4, 2, 16'h2222, 16'h0022, 0, 1));
      tbl.push_back(mk(1, 4'hF, 4'h4, 2, 16'h1234, 16'h0034, 1, 1));
      tbl.push_back(mk(1, 4'hF, 4'h4, 2, 16'h1234, 16'h0034, 1, 1));
      tbl.push_back(mk(1, 4'hB, 4'h8, 3, 16'h1234, 16'h0034, 0, 1));
      tbl.push_back(mk(1, 4'hF, 4'h8, 3, 16'h4444, 16'h0044, 1, 1));
      tbl.push_back(mk(1, 4'hF, 4'h8, 3, 16'h4444, 16'h0044, 1, 1));
      tbl.push_back(mk(1, 4'h7, 4'h1, 0, 16'h4444, 16'h0044, 0, 1));
      tbl.push_back(mk(1, 4'hF, 4'h1, 0, 16'h11AB, 16'h00AB, 1, 1));

      foreach (tbl[i]) begin
         apply(tbl[i].rst, tbl[i].req);
         check($sformatf("table%0d", i), tbl[i].gnt, tbl[i].s, tbl[i].do16, tbl[i].do8,
               tbl[i].dv, tbl[i].busy);
      end

      // Burst behaviour with A and B both requesting continuously.
      apply(1'b0, 4'b0000);
      for (int e = 1; e <= 24; e++) begin
         int own, prev;
         logic [15:0] ed, ed8;
         apply(1'b1, 4'b0011);
`ifdef ARB_BURST_LIMIT_EN
         own  = ((e - 1) / MaxBurst) % 2;
         prev = (e >= 2) ? ((e - 2) / MaxBurst) % 2 : 0;
`else
         own  = 0;
         prev = 0;
`endif
         ed  = (e < 2) ? 16'h0000 : (prev == 0 ? 16'h11AB : 16'h2222);
         ed8 = (e < 2) ? 16'h0000 : (prev == 0 ? 16'h00AB : 16'h0022);
         check($sformatf("burst_e%0d", e), 4'b0001 << own, 2'(own), ed, ed8,
               (e >= 2), 1'b1);
      end

      // Reset in the middle of B's burst drops everything; A wins first afterwards.
      apply(1'b0, 4'b0000);
      apply(1'b1, 4'b0010);
      check("midrst_grant", 4'b0010, 2'd1, 16'h0000, 16'h0000, 1'b0, 1'b1);
      apply(1'b1, 4'b0010);
      check("midrst_beat1", 4'b0010, 2'd1, 16'h2222, 16'h0022, 1'b1, 1'b1);
      apply(1'b0, 4'b0010);
      check("midrst_reset", 4'b0000, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      apply(1'b1, 4'b0011);
      check("midrst_regrant", 4'b0001, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b1);

      // Randomised traffic against the reference model.
      begin
         logic [3:0] r;
         logic       rr;
         r = 4'b0;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom);
            rr = ($urandom_range(63) != 0);
            a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
            apply(rr, r);
            check($sformatf("rand%0d", i), m_gnt, m_s, m_do, m_do8, m_dv, !m_idle);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
